// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART RX frame FSM driving edge_counter and deserializing sampled bits LSB-first.
// Optional UART_RX_ERR_CNT_EN adds a saturating per-frame error counter o_err_count.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_in,
  input  logic [1:0]            i_prescale,
  input  logic                  i_parity_enable,
  input  logic                  i_parity_type,
  input  logic                  i_sampled_bit,
  output logic [5:0]            o_edge_counter,
  output logic                  o_sample_enable,
  output logic [DATA_WIDTH-1:0] o_parallel_data,
  output logic                  o_data_valid,
  output logic                  o_parity_error,
  output logic                  o_stop_error,
  output logic                  o_busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            o_err_count
`endif
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                r_state;
  logic [1:0]            r_prescale;
  logic                  r_pen;
  logic                  r_ptype;
  logic                  r_bad;
  logic [5:0]            r_cnt;
  logic [BW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [5:0]            w_last;
  logic                  w_bit_end;
  logic                  w_go;
  logic                  w_par_bad;
  assign w_last    = r_prescale == 2'b01 ? 6'd15 : r_prescale == 2'b10 ? 6'd31 : 6'd7;
  assign w_bit_end = r_cnt == w_last;
  // A low line at the stop-bit end chains straight into the next frame, losing no cycle.
  assign w_go      = !i_rx_in && (r_state == IDLE || (r_state == STOP && w_bit_end));
  assign w_par_bad = i_sampled_bit != (^r_shift ^ r_ptype);
  assign o_edge_counter  = r_cnt;
  assign o_busy          = r_state != IDLE;
  assign o_sample_enable = r_state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_prescale      <= 2'b00;
      r_pen           <= 1'b0;
      r_ptype         <= 1'b0;
      r_bad           <= 1'b0;
      r_cnt           <= 6'd0;
      r_idx           <= '0;
      r_shift         <= '0;
      o_parallel_data <= '0;
      o_data_valid    <= 1'b0;
      o_parity_error  <= 1'b0;
      o_stop_error    <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      o_err_count     <= 8'd0;
`endif
    end else begin
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      r_cnt          <= (r_state == IDLE || w_bit_end) ? 6'd0 : r_cnt + 6'd1;
      if (w_go) begin
        r_prescale <= i_prescale;
        r_pen      <= i_parity_enable;
        r_ptype    <= i_parity_type;
        r_bad      <= 1'b0;
        r_state    <= START;
      end
      case (r_state)
        START: if (w_bit_end) begin
          r_state <= i_sampled_bit ? IDLE : DATA;
          r_idx   <= '0;
        end
        DATA: if (w_bit_end) begin
          r_shift <= {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
          r_idx   <= r_idx + 1'b1;
          if (r_idx == BW'(DATA_WIDTH - 1)) r_state <= r_pen ? PARITY : STOP;
        end
        PARITY: if (w_bit_end) begin
          o_parity_error <= w_par_bad;
          r_bad          <= w_par_bad;
          r_state        <= STOP;
        end
        STOP: if (w_bit_end) begin
          o_stop_error <= !i_sampled_bit;
          o_data_valid <= i_sampled_bit && !r_bad;
          if (i_sampled_bit && !r_bad) o_parallel_data <= r_shift;
`ifdef UART_RX_ERR_CNT_EN
          if ((r_bad || !i_sampled_bit) && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
`endif
          if (i_rx_in) r_state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed scenarios for uart_rx_frame_ctrl with hand-computed expectations.
module tb_uart_rx_frame_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       rx = 1;
  logic [1:0] presc = 2'b00;
  logic       pen = 0;
  logic       ptype = 0;
  logic       sb = 1;
  logic [5:0] edge_cnt;
  logic       sen, dv, pe, se, busy;
  logic [7:0] pdata;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] errc;
`endif
  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;
  int dv_n = 0, pe_n = 0, se_n = 0, dv_cyc = 0, pe_cyc = 0, se_cyc = 0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_in(rx), .i_prescale(presc),
    .i_parity_enable(pen), .i_parity_type(ptype), .i_sampled_bit(sb),
    .o_edge_counter(edge_cnt), .o_sample_enable(sen), .o_parallel_data(pdata),
    .o_data_valid(dv), .o_parity_error(pe), .o_stop_error(se), .o_busy(busy)
`ifdef UART_RX_ERR_CNT_EN
    , .o_err_count(errc)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dv) begin dv_n <= dv_n + 1; dv_cyc <= cyc; end
    if (pe) begin pe_n <= pe_n + 1; pe_cyc <= cyc; end
    if (se) begin se_n <= se_n + 1; se_cyc <= cyc; end
  end

  // Drives one frame with rx and sampled_bit following the bit values for n clocks each.
  // cont: the start edge already happened; chain: drop rx on the last stop cycle.
  task automatic send(input int n, input logic [7:0] d, input bit p_en, input bit p_bit,
                      input bit stop_bit, input bit cont, input bit chain);
    logic b[11];
    int nb;
    nb = 10 + int'(p_en);
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[1+k] = d[k];
    if (p_en) b[9] = p_bit;
    b[nb-1] = stop_bit;
    if (!cont) begin
      @(negedge clk); rx = 0; sb = 0;
      @(posedge clk); #1;
    end
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = b[i]; sb = b[i];
      if (i == nb - 1 && chain) begin
        repeat (n - 1) @(posedge clk);
        #1 rx = 0;
        @(posedge clk); #1;
      end else begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    if (!chain) begin rx = 1; sb = 1; end
  endtask

  task automatic test_reset;
    #2;
    total++; if (edge_cnt !== 6'd0) begin bad++; $display("FAIL reset_edge got=%0d exp=0", edge_cnt); end
    total++; if (pdata !== 8'h00) begin bad++; $display("FAIL reset_pdata got=%0h exp=0", pdata); end
    total++; if ({dv, pe, se, busy, sen} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {dv, pe, se, busy, sen}); end
`ifdef UART_RX_ERR_CNT_EN
    total++; if (errc !== 8'd0) begin bad++; $display("FAIL reset_errc got=%0d exp=0", errc); end
`endif
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_x8_basic;
    int d0;
    presc = 2'b00; pen = 0; d0 = dv_n;
    send(8, 8'hAD, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    total++; if (dv_n !== d0 + 1) begin bad++; $display("FAIL x8_dv_count got=%0d exp=%0d", dv_n - d0, 1); end
    total++; if (dv_cyc - t0 !== 80) begin bad++; $display("FAIL x8_dv_time got=%0d exp=80", dv_cyc - t0); end
    total++; if (pdata !== 8'hAD) begin bad++; $display("FAIL x8_pdata got=%0h exp=ad", pdata); end
    total++; if (pe_n + se_n !== 0) begin bad++; $display("FAIL x8_errors got=%0d exp=0", pe_n + se_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL x8_busy got=%b exp=0", busy); end
  endtask

  task automatic test_parity;
    int d0, p0;
    presc = 2'b01; pen = 1; ptype = 0; d0 = dv_n;
    send(16, 8'h35, 1, 0, 1, 0, 0);
    @(negedge clk); #1;
    total++; if (dv_n !== d0 + 1) begin bad++; $display("FAIL par_ok_dv got=%0d exp=1", dv_n - d0); end
    total++; if (dv_cyc - t0 !== 176) begin bad++; $display("FAIL par_ok_time got=%0d exp=176", dv_cyc - t0); end
    total++; if (pdata !== 8'h35) begin bad++; $display("FAIL par_ok_pdata got=%0h exp=35", pdata); end
    d0 = dv_n; p0 = pe_n;
    send(16, 8'h35, 1, 1, 1, 0, 0);
    @(negedge clk); #1;
    total++; if (pe_n !== p0 + 1) begin bad++; $display("FAIL par_bad_pe got=%0d exp=1", pe_n - p0); end
    total++; if (pe_cyc - t0 !== 160) begin bad++; $display("FAIL par_bad_time got=%0d exp=160", pe_cyc - t0); end
    total++; if (dv_n !== d0) begin bad++; $display("FAIL par_bad_dv got=%0d exp=0", dv_n - d0); end
    total++; if (pdata !== 8'h35) begin bad++; $display("FAIL par_bad_pdata got=%0h exp=35", pdata); end
  endtask

  task automatic test_stop_error;
    int d0, s0;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] e0;
    e0 = errc;
`endif
    presc = 2'b10; pen = 0; d0 = dv_n; s0 = se_n;
    send(32, 8'h5A, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    total++; if (se_n !== s0 + 1) begin bad++; $display("FAIL stop_se got=%0d exp=1", se_n - s0); end
    total++; if (se_cyc - t0 !== 320) begin bad++; $display("FAIL stop_time got=%0d exp=320", se_cyc - t0); end
    total++; if (dv_n !== d0) begin bad++; $display("FAIL stop_dv got=%0d exp=0", dv_n - d0); end
    total++; if (pdata !== 8'h35) begin bad++; $display("FAIL stop_pdata got=%0h exp=35", pdata); end
`ifdef UART_RX_ERR_CNT_EN
    total++; if (errc !== e0 + 8'd1) begin bad++; $display("FAIL stop_errc got=%0d exp=%0d", errc, e0 + 8'd1); end
`endif
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_settle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int f0;
    presc = 2'b00; pen = 0; f0 = dv_n + pe_n + se_n;
    @(negedge clk); rx = 0; sb = 1;
    @(posedge clk); #1 rx = 1;
    total++; if (busy !== 1'b1 || edge_cnt !== 6'd0) begin bad++; $display("FAIL glitch_enter got=%b/%0d exp=1/0", busy, edge_cnt); end
    repeat (7) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || edge_cnt !== 6'd7) begin bad++; $display("FAIL glitch_hold got=%b/%0d exp=1/7", busy, edge_cnt); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_exit got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    total++; if (dv_n + pe_n + se_n !== f0) begin bad++; $display("FAIL glitch_flags got=%0d exp=%0d", dv_n + pe_n + se_n, f0); end
  endtask

  task automatic test_back_to_back;
    int d0, c1;
    presc = 2'b00; pen = 0; d0 = dv_n;
    send(8, 8'h01, 0, 0, 1, 0, 1);
    @(negedge clk); #1;
    total++; if (dv_n !== d0 + 1 || pdata !== 8'h01) begin bad++; $display("FAIL b2b_first got=%0d/%0h exp=1/01", dv_n - d0, pdata); end
    c1 = dv_cyc;
    send(8, 8'hFF, 0, 0, 1, 1, 0);
    @(negedge clk); #1;
    total++; if (dv_n !== d0 + 2 || pdata !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%0d/%0h exp=2/ff", dv_n - d0, pdata); end
    total++; if (dv_cyc - c1 !== 80) begin bad++; $display("FAIL b2b_spacing got=%0d exp=80", dv_cyc - c1); end
  endtask

  task automatic test_reset_mid;
    int d0;
    presc = 2'b00; pen = 0;
    @(negedge clk); rx = 0; sb = 0;
    repeat (20) @(posedge clk);
    #3 rst_n = 0;
    #1;
    total++; if ({busy, sen, dv, pe, se} !== 5'b0 || edge_cnt !== 6'd0) begin bad++; $display("FAIL rstmid_flags got=%b/%0d exp=00000/0", {busy, sen, dv, pe, se}, edge_cnt); end
    total++; if (pdata !== 8'h00) begin bad++; $display("FAIL rstmid_pdata got=%0h exp=0", pdata); end
    rx = 1; sb = 1;
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    d0 = dv_n;
    send(8, 8'hC3, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    total++; if (dv_n !== d0 + 1 || pdata !== 8'hC3) begin bad++; $display("FAIL rstmid_frame got=%0d/%0h exp=1/c3", dv_n - d0, pdata); end
    total++; if (dv_cyc - t0 !== 80) begin bad++; $display("FAIL rstmid_time got=%0d exp=80", dv_cyc - t0); end
  endtask

  initial begin
    test_reset;
    test_x8_basic;
    test_parity;
    test_stop_error;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
